// File: rtl/xcorr_pkg.sv
// xcorr_pkg: shared types and helpers for the xcorr peak scheduler
package xcorr_pkg;
    localparam int NUM_XCORRS = 6;
    typedef enum logic [2:0] {FILL, ARMED, WAIT, SCAN, DONE} sched_state_t;
    typedef enum logic [2:0] {PAIR_01, PAIR_02, PAIR_03, PAIR_12, PAIR_13, PAIR_23} pair_t;
    function automatic int lag_bits(input int d);
        return $clog2(d + 1) + 1;
    endfunction
endpackage

// File: rtl/xcorr_argmax_lane.sv
// xcorr_argmax_lane: snapshot of one pair's xcorr vector plus running signed max/argmax.
// Peak value is exported only when XCORR_PEAK_VALUE_OUT_EN is defined.
module xcorr_argmax_lane #(
    parameter int W  = 34,
    parameter int N  = 23,
    parameter int IB = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [IB-1:0]         index,
    input  logic [N-1:0][W-1:0]   vec,
    output logic [IB-1:0]         arg_next
`ifdef XCORR_PEAK_VALUE_OUT_EN
    ,
    output logic [W-1:0]          peak_next
`endif
);
    logic [N-1:0][W-1:0] snap;
    logic signed [W-1:0] max_q, max_next, cur;
    logic [IB-1:0] arg_q;
    logic upd;
    // index 0 seeds the scan; strict > keeps the lowest index on ties
    always_comb begin
        cur      = snap[index];
        upd      = step && (index == '0 || cur > max_q);
        max_next = upd ? cur : max_q;
        arg_next = upd ? index : arg_q;
    end
`ifdef XCORR_PEAK_VALUE_OUT_EN
    assign peak_next = max_next;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap  <= '0;
            max_q <= '0;
            arg_q <= '0;
        end else begin
            if (load) snap <= vec;
            max_q <= max_next;
            arg_q <= arg_next;
        end
    end
endmodule

// File: rtl/xcorr_peak_scheduler.sv
// xcorr_peak_scheduler: periodic snapshot of xcorr vectors and per-pair signed peak lag output.
// Optional peakOut port enabled by XCORR_PEAK_VALUE_OUT_EN.
module xcorr_peak_scheduler
    import xcorr_pkg::*;
#(
    parameter int NUM_BITS_XCORR    = 34,
    parameter int MAX_SAMPLES_DELAY = 11,
    parameter int NUM_SAMPLES       = 100,
    parameter int UPDATE_INTERVAL   = 50,
    parameter int PIPE_LATENCY      = 2,
    parameter int LAG_BITS          = lag_bits(MAX_SAMPLES_DELAY)
) (
    input  logic clk,
    input  logic rst,
    input  logic validIn,
    input  logic [NUM_XCORRS-1:0][2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0] xCorrIn,
    output logic [NUM_XCORRS-1:0][LAG_BITS-1:0] lagOut,
    output logic validOut,
    input  logic readyIn,
    output logic busy,
    output logic overrun,
    output logic primed
`ifdef XCORR_PEAK_VALUE_OUT_EN
    ,
    output logic [NUM_XCORRS-1:0][NUM_BITS_XCORR-1:0] peakOut
`endif
);
    localparam int N  = 2 * MAX_SAMPLES_DELAY + 1;
    localparam int IB = $clog2(N);
    localparam int FB = $clog2(NUM_SAMPLES + 1);
    localparam int UB = $clog2(UPDATE_INTERVAL + 1);
    localparam int PB = $clog2(PIPE_LATENCY + 1);

    sched_state_t state, state_n;
    logic [FB-1:0] fill_cnt;
    logic [UB-1:0] int_cnt;
    logic [PB-1:0] dly;
    logic [IB-1:0] idx;
    logic [NUM_XCORRS-1:0][IB-1:0] arg_n;
    logic trig, fill_done, cap, scan_end;

    assign fill_done = state == FILL && validIn && fill_cnt == FB'(NUM_SAMPLES - 1);
    assign trig      = validIn && state != FILL && int_cnt == UB'(UPDATE_INTERVAL - 1);
    assign cap       = state == WAIT && dly == PB'(1);
    assign scan_end  = state == SCAN && idx == IB'(N - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_n;
    end

    always_comb begin
        state_n = fill_done                     ? ARMED :
                  (state == ARMED && trig)      ? WAIT  :
                  cap                           ? SCAN  :
                  scan_end                      ? DONE  :
                  (state == DONE && readyIn)    ? ARMED : state;
    end

    always_comb begin
        busy     = state == WAIT || state == SCAN || state == DONE;
        validOut = state == DONE;
        primed   = state != FILL;
    end

    // interval counter free-runs outside FILL so snapshot phase never drifts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt <= '0;
            int_cnt  <= '0;
            dly      <= '0;
            idx      <= '0;
            overrun  <= 1'b0;
            lagOut   <= '0;
        end else begin
            if (state == FILL && validIn) fill_cnt <= fill_cnt + 1'b1;
            if (validIn && state != FILL) int_cnt <= trig ? '0 : int_cnt + 1'b1;
            if (state == ARMED && trig) dly <= PB'(PIPE_LATENCY);
            else if (state == WAIT) dly <= dly - 1'b1;
            if (state == SCAN) idx <= scan_end ? '0 : idx + 1'b1;
            overrun <= trig && busy;
            if (scan_end)
                for (int p = 0; p < NUM_XCORRS; p++)
                    lagOut[p] <= LAG_BITS'(arg_n[p]) - LAG_BITS'(MAX_SAMPLES_DELAY);
        end
    end

`ifdef XCORR_PEAK_VALUE_OUT_EN
    logic [NUM_XCORRS-1:0][NUM_BITS_XCORR-1:0] max_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) peakOut <= '0;
        else if (scan_end) peakOut <= max_n;
    end
`endif

    for (genvar i = 0; i < NUM_XCORRS; i++) begin : g_lane
        xcorr_argmax_lane #(.W(NUM_BITS_XCORR), .N(N), .IB(IB)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (cap),
            .step     (state == SCAN),
            .index    (idx),
            .vec      (xCorrIn[i]),
            .arg_next (arg_n[i])
`ifdef XCORR_PEAK_VALUE_OUT_EN
            ,
            .peak_next(max_n[i])
`endif
        );
    end
endmodule

// File: tb/tb_xcorr_peak_scheduler.sv
// tb_xcorr_peak_scheduler: randomized bench with a timing-based reference model for two configurations.
module tb_xcorr_peak_scheduler;
    localparam int NS0 = 100, UI0 = 50, PL0 = 2;
    localparam int NS1 = 8,   UI1 = 4,  PL1 = 3;
    localparam int NV = 23, D = 11;

    logic clk = 1'b0;
    logic [1:0] rsts, vins, rdys, val, bsy, ovr, prm;
    logic [5:0][22:0][33:0] xc;
    logic [5:0][4:0] lag [2];
`ifdef XCORR_PEAK_VALUE_OUT_EN
    logic [5:0][33:0] pk [2];
`endif
    int cyc = 0, n_chk = 0, n_fail = 0;
    int ov_cnt [2] = '{0, 0};
    bit rand_xc = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xcorr_peak_scheduler dut0 (
        .clk(clk), .rst(rsts[0]), .validIn(vins[0]), .xCorrIn(xc), .lagOut(lag[0]),
        .validOut(val[0]), .readyIn(rdys[0]), .busy(bsy[0]), .overrun(ovr[0]), .primed(prm[0])
`ifdef XCORR_PEAK_VALUE_OUT_EN
        , .peakOut(pk[0])
`endif
    );
    xcorr_peak_scheduler #(.NUM_SAMPLES(NS1), .UPDATE_INTERVAL(UI1), .PIPE_LATENCY(PL1)) dut1 (
        .clk(clk), .rst(rsts[1]), .validIn(vins[1]), .xCorrIn(xc), .lagOut(lag[1]),
        .validOut(val[1]), .readyIn(rdys[1]), .busy(bsy[1]), .overrun(ovr[1]), .primed(prm[1])
`ifdef XCORR_PEAK_VALUE_OUT_EN
        , .peakOut(pk[1])
`endif
    );

    // reference model state: pulses since reset and cycle of the accepted trigger (-1 = none)
    int pulses [2] = '{0, 0};
    int tt [2] = '{-1, -1};
    bit e_val [2], e_bsy [2], e_ovr [2], e_prm [2];
    logic [5:0][4:0] e_lag [2], res_lag [2];
    logic [5:0][33:0] e_pk [2], res_pk [2];

    task automatic chk(string nm, int k, logic [63:0] got, logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", nm, k, cyc, got, want);
        end
    endtask

    function automatic logic [4:0] lg(int v);
        return 5'(v);
    endfunction

    task automatic snapshot(int k);
        for (int p = 0; p < 6; p++) begin
            int best = 0;
            for (int i = 1; i < NV; i++)
                if ($signed(xc[p][i]) > $signed(xc[p][best])) best = i;
            res_lag[k][p] = lg(best - D);
            res_pk[k][p]  = xc[p][best];
        end
    endtask

    task automatic advance(int k);
        int ns = k ? NS1 : NS0;
        int ui = k ? UI1 : UI0;
        int pl = k ? PL1 : PL0;
        int c = cyc;
        bit cur_busy = tt[k] >= 0;
        bit trig = vins[k] && pulses[k] >= ns && ((pulses[k] + 1 - ns) % ui == 0);
        e_ovr[k] = trig && cur_busy;
        if (cur_busy && c == tt[k] + pl) snapshot(k);
        if (cur_busy && c >= tt[k] + pl + NV + 1 && rdys[k]) tt[k] = -1;
        else if (trig && !cur_busy) tt[k] = c;
        if (vins[k]) pulses[k]++;
        e_prm[k] = pulses[k] >= ns;
        e_bsy[k] = tt[k] >= 0;
        e_val[k] = tt[k] >= 0 && c + 1 >= tt[k] + pl + NV + 1;
        if (tt[k] >= 0 && c + 1 == tt[k] + pl + NV + 1) begin
            e_lag[k] = res_lag[k];
            e_pk[k]  = res_pk[k];
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rsts[k]) begin
                pulses[k] = 0; tt[k] = -1;
                e_val[k] = 0; e_bsy[k] = 0; e_ovr[k] = 0; e_prm[k] = 0;
                e_lag[k] = '0; e_pk[k] = '0;
            end
            if (ovr[k]) ov_cnt[k]++;
            chk("validOut", k, val[k], e_val[k]);
            chk("busy", k, bsy[k], e_bsy[k]);
            chk("overrun", k, ovr[k], e_ovr[k]);
            chk("primed", k, prm[k], e_prm[k]);
            chk("lagOut", k, lag[k], e_lag[k]);
`ifdef XCORR_PEAK_VALUE_OUT_EN
            for (int p = 0; p < 6; p++) chk("peakOut", k, pk[k][p], e_pk[k][p]);
`endif
            if (!rsts[k]) advance(k);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_xc)
            for (int p = 0; p < 6; p++)
                for (int i = 0; i < NV; i++)
                    xc[p][i] = $urandom_range(0, 1) ? 34'($signed(3'($urandom))) : 34'({$urandom, $urandom});
    endtask

    task automatic send(int k, int n);
        for (int i = 0; i < n; i++) begin
            vins[k] = 1'b1;
            tick();
            vins[k] = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    // fires the trigger pulse and waits (bounded) for validOut; returns latency in cycles
    task automatic trigger_and_wait(int k, int bound, output int lat);
        int t0, n;
        vins[k] = 1'b1;
        t0 = cyc;
        tick();
        vins[k] = 1'b0;
        chk("busy_after_trig", k, bsy[k], 1);
        n = 0;
        while (!val[k] && n < bound) begin tick(); n++; end
        lat = cyc - t0;
    endtask

    task automatic set_peak_vec();
        xc = '0;
        xc[0][15] = 34'd1000;
        for (int i = 0; i < NV; i++) begin
            xc[1][i] = 34'(-1000);
            xc[2][i] = 34'(-5);
            xc[4][i] = 34'h2_0000_0000;
        end
        xc[1][3]  = 34'(-100);
        xc[1][20] = 34'(-1);
        xc[3][4]  = 34'd20;
        xc[3][9]  = 34'd20;
        xc[4][22] = 34'h1_FFFF_FFFF;
        xc[5][0]  = 34'd7;
    endtask

    initial begin
        int lat, ov0;
        int exp_lag [6] = '{4, 9, -11, -7, 11, -11};
        rsts = 2'b11; vins = '0; rdys = '0; xc = '0;
        repeat (3) tick();
        rsts = '0;
        tick();
        chk("rst_primed", 0, prm[0], 0);
        chk("rst_valid", 0, val[0], 0);
        chk("rst_lag", 0, lag[0], 0);

        // fill: 99 pulses are not enough, the 100th primes
        send(0, 99);
        chk("fill99_primed", 0, prm[0], 0);
        chk("fill99_busy", 0, bsy[0], 0);
        send(0, 1);
        chk("fill100_primed", 0, prm[0], 1);

        // peak detect, ties and sign on the 50th pulse after priming
        send(0, 49);
        rand_xc = 1'b0;
        set_peak_vec();
        trigger_and_wait(0, 40, lat);
        chk("latency", 0, lat, 26);
        for (int p = 0; p < 6; p++) chk("lit_lag", p, lag[0][p], lg(exp_lag[p]));
`ifdef XCORR_PEAK_VALUE_OUT_EN
        chk("lit_peak0", 0, pk[0][0], 34'd1000);
        chk("lit_peak5", 0, pk[0][5], 34'd7);
`endif
        rand_xc = 1'b1;
        repeat (3) tick();
        rdys[0] = 1'b1;
        tick();
        rdys[0] = 1'b0;
        chk("release_valid", 0, val[0], 0);
        chk("release_busy", 0, bsy[0], 0);

        // reset during SCAN index 10
        send(0, 49);
        vins[0] = 1'b1;
        tick();
        vins[0] = 1'b0;
        repeat (12) tick();
        rsts[0] = 1'b1;
        #1;
        chk("midrst_busy", 0, bsy[0], 0);
        chk("midrst_primed", 0, prm[0], 0);
        chk("midrst_valid", 0, val[0], 0);
        chk("midrst_lag", 0, lag[0], 0);
        tick(); tick();
        rsts[0] = 1'b0;
        send(0, 99);
        chk("refill99_primed", 0, prm[0], 0);
        send(0, 1);
        chk("refill100_primed", 0, prm[0], 1);

        for (int i = 0; i < 800; i++) begin
            vins[0] = 1'($urandom_range(0, 1));
            rdys[0] = $urandom_range(0, 3) != 0;
            tick();
        end
        vins[0] = 1'b0; rdys[0] = 1'b1;
        repeat (30) tick();
        rdys[0] = 1'b0;

        // backpressure and overrun with interval 4
        send(1, 8);
        chk("b_primed", 1, prm[1], 1);
        send(1, 3);
        trigger_and_wait(1, 60, lat);
        chk("b_latency", 1, lat, 27);
        ov0 = ov_cnt[1];
        send(1, 4);
        tick(); tick();
        chk("b_overrun_count", 1, ov_cnt[1] - ov0, 1);
        chk("b_still_valid", 1, val[1], 1);
        rdys[1] = 1'b1;
        tick();
        rdys[1] = 1'b0;
        chk("b_release_valid", 1, val[1], 0);
        chk("b_release_busy", 1, bsy[1], 0);
        send(1, 3);
        trigger_and_wait(1, 60, lat);
        chk("b_latency2", 1, lat, 27);

        for (int i = 0; i < 1500; i++) begin
            vins[1] = 1'($urandom_range(0, 1));
            rdys[1] = $urandom_range(0, 3) == 0;
            tick();
        end
        vins[1] = 1'b0;
        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
